// File: rtl/audio_adc_read.sv
// rtl/audio_adc_read.sv - serial ADC reader: cs/sclk generation, MSB-first capture, quiet gap
module audio_adc_read #(
    parameter int NBITS     = 16,
    parameter int SCLK_DIV  = 4,
    parameter int QUIET_CYC = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_conv,
    input  logic             SDATA,
    output logic             cs,
    output logic             sclk,
    output logic [NBITS-1:0] data_out,
    output logic             ready,
    output logic             dat_valid
);

    localparam int HW = $clog2(SCLK_DIV + 1);
    localparam int BW = $clog2(NBITS + 1);
    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam logic [HW-1:0] HMAX  = HW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(NBITS - 1);
    localparam logic [QW-1:0] QLAST = QW'(QUIET_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

    state_t           state_q, state_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             ready_q, ready_d;
    logic             dat_valid_q, dat_valid_d;
    logic [NBITS-1:0] data_out_q, data_out_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [QW-1:0]    qcnt_q, qcnt_d;

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        ready_d     = ready_q;
        dat_valid_d = 1'b0;
        data_out_d  = data_out_q;
        shift_d     = shift_q;
        hcnt_d      = hcnt_q;
        bcnt_d      = bcnt_q;
        qcnt_d      = qcnt_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (ready_q && start_conv) begin
                    state_d = SHIFT;
                    ready_d = 1'b0;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b1;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (hcnt_q == HMAX) begin
                    hcnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else begin
                        // rising sclk edge: the ADC has held this bit since the fall
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[NBITS-2:0], SDATA};
                        bcnt_d  = bcnt_q + BW'(1);
                        if (bcnt_q == BLAST) begin
                            data_out_d  = {shift_q[NBITS-2:0], SDATA};
                            dat_valid_d = 1'b1;
                            cs_d        = 1'b1;
                            state_d     = QUIET;
                            qcnt_d      = '0;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            QUIET: begin
                if (qcnt_q == QLAST) begin
                    state_d = IDLE;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            ready_q     <= 1'b0;
            dat_valid_q <= 1'b0;
            data_out_q  <= '0;
            shift_q     <= '0;
            hcnt_q      <= '0;
            bcnt_q      <= '0;
            qcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            ready_q     <= ready_d;
            dat_valid_q <= dat_valid_d;
            data_out_q  <= data_out_d;
            shift_q     <= shift_d;
            hcnt_q      <= hcnt_d;
            bcnt_q      <= bcnt_d;
            qcnt_q      <= qcnt_d;
        end
    end

    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign ready     = ready_q;
    assign dat_valid = dat_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_audio_adc_read.sv
// tb/tb_audio_adc_read.sv - directed bench for audio_adc_read with a behavioural ADC
module tb_audio_adc_read;

    localparam int NBITS   = 16;
    localparam int LAT_DV  = 128;
    localparam int LAT_RDY = 133;
    localparam int B2B_GAP = 134;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start_conv = 1'b0;
    logic              SDATA = 1'b0;
    logic              cs, sclk, ready, dat_valid;
    logic [NBITS-1:0]  data_out;

    logic [NBITS-1:0]  tx_word = '0;
    int                bit_idx = 0;
    int                fall_cnt = 0;
    int                dv_cnt = 0;
    int                bad_idle = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    audio_adc_read #(.NBITS(NBITS), .SCLK_DIV(4), .QUIET_CYC(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_conv (start_conv),
        .SDATA      (SDATA),
        .cs         (cs),
        .sclk       (sclk),
        .data_out   (data_out),
        .ready      (ready),
        .dat_valid  (dat_valid)
    );

    always #5 clk = ~clk;

    // ADC model: restart at cs fall, present next bit after every sclk fall
    always @(negedge cs) bit_idx = NBITS - 1;
    always @(negedge sclk) begin
        fall_cnt = fall_cnt + 1;
        if (!cs && bit_idx >= 0) begin
            SDATA   = tx_word[bit_idx];
            bit_idx = bit_idx - 1;
        end
    end

    always @(negedge clk) begin
        if (dat_valid) dv_cnt = dv_cnt + 1;
        if (cs && !sclk) bad_idle = bad_idle + 1;
    end

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        expect_eq("ready_timeout", 32'(ready), 32'd1);
    endtask

    // one conversion from an idle DUT; optionally wiggle start_conv while busy
    task automatic run_conv(input string tag, input logic [NBITS-1:0] word, input bit wiggle);
        int k;
        int dv0;
        wait_ready();
        @(negedge clk);
        tx_word    = word;
        fall_cnt   = 0;
        dv0        = dv_cnt;
        start_conv = 1'b1;
        @(posedge clk); #1;
        start_conv = 1'b0;
        expect_eq({tag, "_ready_low"}, 32'(ready), 32'd0);
        expect_eq({tag, "_cs_low"}, 32'(cs), 32'd0);
        k = 0;
        while (!dat_valid && k < 1000) begin
            if (wiggle) start_conv = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        start_conv = 1'b0;
        expect_eq({tag, "_dv_latency"}, 32'(k), 32'(LAT_DV));
        expect_eq({tag, "_data"}, 32'(data_out), 32'(word));
        expect_eq({tag, "_cs_high"}, 32'(cs), 32'd1);
        @(posedge clk); #1;
        k++;
        expect_eq({tag, "_dv_one_clk"}, 32'(dat_valid), 32'd0);
        while (!ready && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        expect_eq({tag, "_ready_latency"}, 32'(k), 32'(LAT_RDY));
        expect_eq({tag, "_sclk_pulses"}, 32'(fall_cnt), 32'(NBITS));
        expect_eq({tag, "_dv_count"}, 32'(dv_cnt - dv0), 32'd1);
        expect_eq({tag, "_data_hold"}, 32'(data_out), 32'(word));
    endtask

    initial begin
        int k;
        int rdy_hi;
        int dv0;
        logic [NBITS-1:0] rw;

        repeat (4) @(posedge clk);
        #1;
        expect_eq("rst_cs", 32'(cs), 32'd1);
        expect_eq("rst_sclk", 32'(sclk), 32'd1);
        expect_eq("rst_ready", 32'(ready), 32'd0);
        expect_eq("rst_dv", 32'(dat_valid), 32'd0);
        expect_eq("rst_data", 32'(data_out), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        expect_eq("rst_release_ready", 32'(ready), 32'd1);

        run_conv("single", 16'hA5C3, 1'b0);
        run_conv("busy_ignore", 16'h3C96, 1'b1);

        // back-to-back: start_conv held through two conversions
        @(negedge clk);
        tx_word    = 16'h1234;
        start_conv = 1'b1;
        k = 0;
        while (!dat_valid && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        expect_eq("b2b_first_data", 32'(data_out), 32'h1234);
        tx_word = 16'hFEDC;
        k = 0;
        rdy_hi = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (ready) rdy_hi++;
        end while (!dat_valid && k < 1000);
        start_conv = 1'b0;
        expect_eq("b2b_gap", 32'(k), 32'(B2B_GAP));
        expect_eq("b2b_ready_cycles", 32'(rdy_hi), 32'd1);
        expect_eq("b2b_second_data", 32'(data_out), 32'hFEDC);

        // reset after 5 sclk pulses discards the partial sample
        wait_ready();
        @(negedge clk);
        tx_word    = 16'h0F0F;
        start_conv = 1'b1;
        @(posedge clk); #1;
        start_conv = 1'b0;
        dv0 = dv_cnt;
        repeat (42) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        expect_eq("midrst_cs", 32'(cs), 32'd1);
        expect_eq("midrst_sclk", 32'(sclk), 32'd1);
        expect_eq("midrst_data", 32'(data_out), 32'd0);
        expect_eq("midrst_ready", 32'(ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        expect_eq("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
        run_conv("after_rst", 16'hC0DE, 1'b0);

        run_conv("all_ones", 16'hFFFF, 1'b0);
        run_conv("alt_bits", 16'hAAAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rw = NBITS'($urandom);
            run_conv("random", rw, 1'b0);
        end

        expect_eq("sclk_idle_high", 32'(bad_idle), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
